dtc_stream_scorer: RTL
======================

Name: dtc_stream_scorer

Overview:
- Sequential driver and scorer for the team's combinational decision-tree classifiers (8-bit feature vector in, 2-bit class out).
- Accepts labelled samples on a valid/ready stream and drives each feature vector onto the classifier's input.
- Captures the classifier's prediction, compares it with the label, and emits a per-sample result stream.
- Accumulates running accuracy counters for on-chip evaluation of a tree.

Parameters:
- CNT_W, 16, width of the sample and hit counters; both saturate at 2^CNT_W-1.
- SETTLE, 1, clock cycles allowed for the classifier to settle after clf_inp changes; legal range 1..15.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  scorer can accept a sample.
- s_feat  in  8  feature vector.
- s_label  in  2  ground-truth class.
- s_last  in  1  final sample of the evaluation run.
- clf_inp  out  8  registered feature vector driven to the classifier's inp.
- clf_outp  in  2  classifier prediction (classifier outp).
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_pred  out  2  captured prediction.
- m_label  out  2  label of the same sample.
- m_hit  out  1  m_pred == m_label.
- total_cnt  out  CNT_W  samples scored since reset or clear.
- hit_cnt  out  CNT_W  correct predictions since reset or clear.
- done  out  1  run complete (sticky).
- clear  in  1  synchronous clear of counters and done.

Behaviour:
- Reset values: s_ready=0, clf_inp=0, m_valid=0, m_pred=0, m_label=0, m_hit=0, total_cnt=0, hit_cnt=0, done=0, FSM=IDLE.
- FSM states: IDLE, SETTLE_W, CAPTURE, REPORT, DONE.
- IDLE: s_ready=1. On s_valid&&s_ready:
  - register s_feat into clf_inp; latch s_label and s_last;
  - load the settle counter with SETTLE-1;
  - go to SETTLE_W.
- SETTLE_W: s_ready=0. Decrement the settle counter; when it reaches 0, go to CAPTURE.
- CAPTURE (one cycle):
  - m_pred<=clf_outp, m_label<=latched label, m_hit<=(clf_outp==label);
  - total_cnt+=1; hit_cnt+=1 if hit;
  - m_valid<=1; go to REPORT.
- Latency with SETTLE=1: accept on edge N, capture on edge N+2, m_valid high after edge N+2.
- REPORT: hold m_valid and all m_* stable until m_valid&&m_ready. On that handshake:
  - m_valid<=0;
  - next state is DONE if the latched last flag is set, else IDLE.
  - No new sample is accepted in the handshake cycle.
- DONE: s_ready=0, done=1. Remains in DONE until clear; clear returns the FSM to IDLE.
- clf_inp holds its last value in every state except the accept edge; it is never cleared except by reset.
- Counters saturate at all-ones and do not wrap. hit_cnt <= total_cnt always.
- clear=1 (any state):
  - total_cnt, hit_cnt and done zeroed next edge.
  - In DONE: FSM goes to IDLE.
  - In SETTLE_W/CAPTURE: the sample in flight still completes; its increment is discarded if clear coincides with CAPTURE.
  - In REPORT: m_valid and the result are kept.
- Asynchronous reset mid-operation aborts any sample; no partial result is emitted.
- s_feat/s_label are ignored while s_ready=0.

Optional Feature:
- Macro DTC_SCORER_CONFUSION_EN.
- When defined:
  - adds output conf_cnt (16*CNT_W bits), a 4x4 confusion matrix of saturating counters;
  - entry index = label*4 + pred, packed LSB-first;
  - incremented in CAPTURE; zeroed by reset and by clear.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Hold clf_outp = s_label for 3 samples (feat 8'h08, 8'h48, 8'hC8; labels 0,2,1; last on the 3rd) -> 3 results with m_hit=1; total_cnt=3, hit_cnt=3; done=1 after the 3rd handshake; s_ready=0 in DONE.
- SETTLE=1, one sample accepted at edge N with m_ready=1 -> clf_inp updated at N; m_valid asserted after N+2; s_ready low from N to N+3, high again after N+3.
- Mismatch: label 2'b11, clf_outp 2'b10 -> m_hit=0, m_pred=2'b10, m_label=2'b11; hit_cnt unchanged, total_cnt +1.
- Backpressure: m_ready=0 for 5 cycles while the model's clf_outp changes -> m_* stable, s_ready=0, no counter change; after the handshake, return to IDLE.
- CNT_W=2 with 5 all-hit samples -> total_cnt and hit_cnt stick at 3. Then pulse clear in DONE -> both 0, done=0, FSM in IDLE.
- With DTC_SCORER_CONFUSION_EN, samples (label,pred) = (1,1), (3,0), (3,0) -> entry 5 = 1, entry 12 = 2, all other entries 0.

Source files
------------

// File: rtl/dtc_stream_scorer.sv
// -----------------------------------------------------------------------------
// dtc_stream_scorer
//
// Sequential driver and scorer for a combinational decision-tree classifier
// (8-bit feature vector in, 2-bit class out). Labelled samples arrive on a
// valid/ready stream. Each feature vector is registered onto the classifier
// input and given SETTLE cycles to propagate. The prediction is then captured,
// compared with the label and emitted on a result stream, while running
// accuracy counters are updated.
//
// Parameters:
//   CNT_W   width of the sample / hit counters (saturating at all-ones)
//   SETTLE  classifier settle time in clock cycles, 1..15
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   s_valid/s_ready      sample stream handshake
//   s_feat, s_label      feature vector and ground-truth class
//   s_last               marks the final sample of an evaluation run
//   clf_inp              registered feature vector driven to the classifier
//   clf_outp             classifier prediction
//   m_valid/m_ready      result stream handshake
//   m_pred, m_label      captured prediction and the matching label
//   m_hit                m_pred == m_label
//   total_cnt, hit_cnt   samples scored / correct predictions since clear
//   done                 sticky run-complete flag
//   clear                synchronous clear of the counters and done
//   conf_cnt             (DTC_SCORER_CONFUSION_EN only) 4x4 confusion matrix,
//                        entry label*4+pred packed LSB-first, CNT_W bits each
//
// Optional feature macro: DTC_SCORER_CONFUSION_EN
// -----------------------------------------------------------------------------
module dtc_stream_scorer #(
  parameter int CNT_W  = 16,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_feat,
  input  logic [1:0]       s_label,
  input  logic             s_last,
  output logic [7:0]       clf_inp,
  input  logic [1:0]       clf_outp,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [1:0]       m_pred,
  output logic [1:0]       m_label,
  output logic             m_hit,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             done,
  input  logic             clear
`ifdef DTC_SCORER_CONFUSION_EN
  ,
  output logic [16*CNT_W-1:0] conf_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE_W,
    CAPTURE,
    REPORT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [3:0]       SETTLE_LD  = 4'(SETTLE - 1);

  state_t     state;
  state_t     next_state;
  logic [3:0] settle_cnt;
  logic [1:0] label_q;
  logic       last_q;
  logic       accept;
  logic       handshake;
  logic       hit_now;

  assign accept    = (state == IDLE) && s_valid && s_ready;
  assign handshake = (state == REPORT) && m_valid && m_ready;
  assign hit_now   = (clf_outp == label_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A clear that lands on the final handshake starts a
  // fresh run, so the FSM returns to IDLE instead of parking in DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = SETTLE_W;
      end
      SETTLE_W: begin
        if (settle_cnt == 4'd0) next_state = CAPTURE;
      end
      CAPTURE: begin
        next_state = REPORT;
      end
      REPORT: begin
        if (handshake) next_state = (last_q && !clear) ? DONE : IDLE;
      end
      DONE: begin
        if (clear) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // s_ready and done are registered from the next state. This keeps both
  // low while reset is asserted and glitch-free afterwards. As a result,
  // s_ready first rises one edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready <= 1'b0;
      done    <= 1'b0;
    end else begin
      s_ready <= (next_state == IDLE);
      done    <= (next_state == DONE);
    end
  end

  // Sample intake and settle timing. clf_inp changes only on an accept edge
  // so the classifier sees a stable vector for the whole evaluation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clf_inp    <= 8'd0;
      label_q    <= 2'd0;
      last_q     <= 1'b0;
      settle_cnt <= 4'd0;
    end else if (accept) begin
      clf_inp    <= s_feat;
      label_q    <= s_label;
      last_q     <= s_last;
      settle_cnt <= SETTLE_LD;
    end else if ((state == SETTLE_W) && (settle_cnt != 4'd0)) begin
      settle_cnt <= settle_cnt - 4'd1;
    end
  end

  // Result register. It is loaded once in CAPTURE and then held untouched
  // through REPORT until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_pred  <= 2'd0;
      m_label <= 2'd0;
      m_hit   <= 1'b0;
    end else if (state == CAPTURE) begin
      m_valid <= 1'b1;
      m_pred  <= clf_outp;
      m_label <= label_q;
      m_hit   <= hit_now;
    end else if (handshake) begin
      m_valid <= 1'b0;
    end
  end

  // Accuracy counters. A clear wins over a coincident capture, so that
  // sample's increment is dropped. Both counters saturate, and hit_cnt only
  // steps alongside total_cnt, so hit_cnt never overtakes total_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_cnt <= '0;
      hit_cnt   <= '0;
    end else if (clear) begin
      total_cnt <= '0;
      hit_cnt   <= '0;
    end else if (state == CAPTURE) begin
      if (total_cnt != CNT_MAX) total_cnt <= total_cnt + CNT_ONE;
      if (hit_now && (hit_cnt != CNT_MAX)) hit_cnt <= hit_cnt + CNT_ONE;
    end
  end

`ifdef DTC_SCORER_CONFUSION_EN
  logic [CNT_W-1:0] conf_q [16];
  logic [3:0]       conf_idx;

  assign conf_idx = {label_q, clf_outp};

  // Confusion matrix. A row is selected by the label and a column by the
  // prediction. It follows the same clear and saturation rules as the
  // counters above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) conf_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < 16; i++) conf_q[i] <= '0;
    end else if ((state == CAPTURE) && (conf_q[conf_idx] != CNT_MAX)) begin
      conf_q[conf_idx] <= conf_q[conf_idx] + CNT_ONE;
    end
  end

  // Pack the matrix onto the flat output, entry 0 in the low bits.
  always_comb begin
    conf_cnt = '0;
    for (int i = 0; i < 16; i++) conf_cnt[i*CNT_W +: CNT_W] = conf_q[i];
  end
`endif

endmodule
